// File: rtl/rf_wb_arbiter_pkg.sv
// rf_wb_arbiter_pkg: shared writeback arbiter state encoding and widths
package rf_wb_arbiter_pkg;
  typedef enum logic [0:0] {PRIO_ALU = 1'b0, PRIO_LSU = 1'b1} arb_state_t;
  localparam int REG_AW = 5;
  localparam int XLEN_DEF = 32;
endpackage

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: two-requester register file writeback arbiter with load starvation guard
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int XLEN = XLEN_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [REG_AW-1:0] alu_rd,
  input  logic [XLEN-1:0]   alu_data,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [REG_AW-1:0] lsu_rd,
  input  logic [XLEN-1:0]   lsu_data,
  output logic              wr_en,
  output logic [REG_AW-1:0] wr_reg,
  output logic [XLEN-1:0]   wr_data,
  output logic              starved
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);
  arb_state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic xfer;
  logic [REG_AW-1:0] sel_rd;
  logic [XLEN-1:0] sel_data;
  // readys are forced low during reset so held requests are neither taken nor lost
  always_comb begin
    lsu_ready = rst_n && lsu_valid && (state == PRIO_LSU || !alu_valid);
    alu_ready = rst_n && alu_valid && !(state == PRIO_LSU && lsu_valid);
    xfer = alu_ready || lsu_ready;
    sel_rd = lsu_ready ? lsu_rd : alu_rd;
    sel_data = lsu_ready ? lsu_data : alu_data;
    cnt_nxt = (!lsu_valid || lsu_ready) ? '0 : (cnt == LIM ? cnt : cnt + 1'b1);
    state_nxt = state == PRIO_ALU ? (cnt_nxt == LIM ? PRIO_LSU : PRIO_ALU)
                                  : ((lsu_ready || !lsu_valid) ? PRIO_ALU : PRIO_LSU);
    starved = state == PRIO_LSU;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= PRIO_ALU;
      cnt <= '0;
      wr_en <= 1'b0;
      wr_reg <= '0;
      wr_data <= '0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      wr_en <= xfer && sel_rd != '0;
      if (xfer) begin
        wr_reg <= sel_rd;
        wr_data <= sel_data;
      end
    end
  end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed scoreboard bench for the writeback arbiter
module tb_rf_wb_arbiter;
  typedef struct packed {logic en; logic [4:0] rg; logic [31:0] d;} wr_t;
  logic clk = 1'b0;
  logic rst_n;
  logic alu_valid, alu_ready, lsu_valid, lsu_ready;
  logic [4:0] alu_rd, lsu_rd, wr_reg;
  logic [31:0] alu_data, lsu_data, wr_data;
  logic wr_en, starved;
  int total = 0;
  int bad = 0;
  wr_t sb[$];
  logic [4:0] hold_reg = '0;
  logic [31:0] hold_data = '0;

  rf_wb_arbiter #(.STARVE_LIMIT(4), .XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data), .starved(starved)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                     input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                     input logic ear, input logic elr, input logic est);
    wr_t w;
    alu_valid = av; alu_rd = ard; alu_data = ad;
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
    #1;
    chk("alu_ready", 32'(alu_ready), 32'(ear));
    chk("lsu_ready", 32'(lsu_ready), 32'(elr));
    chk("starved", 32'(starved), 32'(est));
    chk("one_ready", 32'(alu_ready && lsu_ready), 32'd0);
    if (ear) begin hold_reg = ard; hold_data = ad; end
    else if (elr) begin hold_reg = lrd; hold_data = ld; end
    sb.push_back('{en: (ear || elr) && hold_reg != 5'd0, rg: hold_reg, d: hold_data});
    @(posedge clk); #1;
    w = sb.pop_front();
    chk("wr_en", 32'(wr_en), 32'(w.en));
    chk("wr_reg", 32'(wr_reg), 32'(w.rg));
    chk("wr_data", wr_data, w.d);
    chk("zero_write", 32'(wr_en && wr_reg == 5'd0), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h11;
    lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h22;
    @(negedge clk); @(negedge clk);
    chk("rst_alu_ready", 32'(alu_ready), 32'd0);
    chk("rst_lsu_ready", 32'(lsu_ready), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_reg", 32'(wr_reg), 32'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    chk("rst_starved", 32'(starved), 32'd0);
    rst_n = 1'b1;
    cyc(1, 5, 32'hDEADBEEF, 0, 0, 0, 1, 0, 0);
    cyc(1, 0, 32'h1234, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 9, 32'h55, 0, 1, 0);
    // sustained contention: lsu is starved for four cycles then wins once
    for (int i = 0; i < 4; i++) cyc(1, 5'(10 + i), 32'(100 + i), 1, 7, 32'hA5A5A5A5, 1, 0, 0);
    cyc(1, 14, 32'd104, 1, 7, 32'hA5A5A5A5, 0, 1, 1);
    cyc(1, 14, 32'd104, 1, 8, 32'hB0, 1, 0, 0);
    cyc(1, 15, 32'd105, 1, 8, 32'hB0, 1, 0, 0);
    cyc(0, 0, 0, 1, 8, 32'hB0, 0, 1, 0);
    // two lost cycles, lsu withdraws, then a fresh four-cycle starvation window
    cyc(1, 16, 32'd106, 1, 12, 32'hC0, 1, 0, 0);
    cyc(1, 17, 32'd107, 1, 12, 32'hC0, 1, 0, 0);
    cyc(1, 18, 32'd108, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) cyc(1, 5'(19 + i), 32'(200 + i), 1, 13, 32'hD0, 1, 0, 0);
    cyc(1, 23, 32'd204, 1, 13, 32'hD0, 0, 1, 1);
    cyc(1, 23, 32'd204, 0, 0, 0, 1, 0, 0);
    cyc(1, 3, 32'h77, 0, 0, 0, 1, 0, 0);
    alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h44;
    lsu_valid = 1'b1; lsu_rd = 5'd6; lsu_data = 32'h66;
    chk("pre_rst_wr_en", 32'(wr_en), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wr_en", 32'(wr_en), 32'd0);
    chk("mid_rst_wr_reg", 32'(wr_reg), 32'd0);
    chk("mid_rst_alu_ready", 32'(alu_ready), 32'd0);
    chk("mid_rst_lsu_ready", 32'(lsu_ready), 32'd0);
    @(posedge clk); #1;
    chk("mid_rst_hold_wr_en", 32'(wr_en), 32'd0);
    chk("mid_rst_starved", 32'(starved), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    hold_reg = '0; hold_data = '0;
    cyc(1, 4, 32'h44, 1, 6, 32'h66, 1, 0, 0);
    cyc(0, 0, 0, 1, 6, 32'h66, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
